// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: load/store unit between the core MEM stage and a word RAM
// with a ready handshake. Decodes width/sign from funct3, builds byte
// enables and lane-replicated store data, extends load data, stalls the
// pipeline while the RAM is busy, and reports misaligned requests and
// RAM timeouts as single-cycle pulses.
module lsu_mem_bridge #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              misalign,
   output logic              bus_error,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Last ACCESS cycle that may still wait for mem_ready (counter starts at 0).
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [7:0]        cnt;
   logic              lat_we;
   logic [2:0]        lat_funct3;
   logic [1:0]        lat_off;
   logic [ADDR_W-1:0] lat_addr;
   logic [3:0]        lat_be;
   logic [31:0]       lat_wdata;
   logic              timed_out;

   logic              req_legal;
   logic [3:0]        req_be;
   logic [31:0]       req_lane;
   logic              can_accept;
   logic              accept;
   logic              reject;
   logic              expired;
   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [31:0]       load_ext;

   // Upper address bits lie outside the RAM and are deliberately dropped.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   assign can_accept = (state == IDLE) || (state == DONE);
   assign accept     = can_accept && req_valid && req_legal && !RESET;
   assign reject     = can_accept && req_valid && !req_legal;
   assign expired    = (state == ACCESS) && !mem_ready && (cnt == TIMEOUT_LAST);

   // Request decode: legality, byte enables and lane-replicated store data.
   // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      req_legal = 1'b0;
      req_be    = 4'b0000;
      req_lane  = req_wdata;
      case (req_funct3)
         F3_B, F3_BU: begin
            req_legal = !req_we || (req_funct3 == F3_B);
            req_be    = 4'b0001 << req_addr[1:0];
            req_lane  = {4{req_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            req_legal = !req_addr[0] && (!req_we || (req_funct3 == F3_H));
            req_be    = 4'b0011 << {req_addr[1], 1'b0};
            req_lane  = {2{req_wdata[15:0]}};
         end
         F3_W: begin
            req_legal = (req_addr[1:0] == 2'b00);
            req_be    = 4'b1111;
         end
         default: ;
      endcase
   end

   // Load data lane selection and sign/zero extension.
   always_comb begin
      load_byte = mem_rdata[7:0];
      case (lat_off)
         2'd1:    load_byte = mem_rdata[15:8];
         2'd2:    load_byte = mem_rdata[23:16];
         2'd3:    load_byte = mem_rdata[31:24];
         default: load_byte = mem_rdata[7:0];
      endcase
      load_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_funct3)
         F3_B:    load_ext = {{24{load_byte[7]}}, load_byte};
         F3_BU:   load_ext = {24'h0, load_byte};
         F3_H:    load_ext = {{16{load_half[15]}}, load_half};
         F3_HU:   load_ext = {16'h0, load_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // Next state and combinational outputs; RAM signals only driven in ACCESS.
   always_comb begin
      state_nxt   = state;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_be      = 4'b0000;
      mem_wdata   = 32'h0;
      rdata_valid = 1'b0;
      bus_error   = 1'b0;
      case (state)
         IDLE: begin
            stall     = accept;
            state_nxt = accept ? ACCESS : IDLE;
         end
         ACCESS: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_be    = lat_be;
            mem_wdata = lat_wdata;
            if (mem_ready || expired) state_nxt = DONE;
         end
         DONE: begin
            rdata_valid = !lat_we && !timed_out;
            bus_error   = timed_out;
            stall       = accept;
            state_nxt   = accept ? ACCESS : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // Request latch, wait counter, result and status registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt        <= 8'd0;
         lat_we     <= 1'b0;
         lat_funct3 <= 3'b000;
         lat_off    <= 2'b00;
         lat_addr   <= '0;
         lat_be     <= 4'b0000;
         lat_wdata  <= 32'h0;
         timed_out  <= 1'b0;
         misalign   <= 1'b0;
         rdata      <= 32'h0;
      end else begin
         misalign <= reject;
         if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_addr   <= req_addr[ADDR_W+1:2];
            lat_be     <= req_be;
            lat_wdata  <= req_lane;
            timed_out  <= 1'b0;
         end
         if (state == ACCESS) begin
            cnt <= cnt + 8'd1;
            if (mem_ready) begin
               if (!lat_we) rdata <= load_ext;
            end else if (expired) begin
               timed_out <= 1'b1;
               rdata     <= 32'h0;
            end
         end else begin
            cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb_lsu_mem_bridge: scoreboard bench for lsu_mem_bridge. Expected load
// results, misalign and bus_error pulses are queued when a request is
// driven and popped by a monitor when the DUT reports an outcome.
module tb_lsu_mem_bridge;

   logic        CLK;
   logic        RESET;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        misalign;
   logic        bus_error;
   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   typedef enum logic [1:0] {K_DATA, K_MIS, K_BERR} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int          ram_wait = 0;
   logic [31:0] ram_word = 32'h0;
   int          acc_cnt = 0;

   lsu_mem_bridge dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
      .misalign(misalign), .bus_error(bus_error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // RAM model: ready after ram_wait wait states (negative = never).
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
      forever begin
         @(negedge CLK);
         if (mem_req === 1'b1) begin
            mem_ready = (ram_wait >= 0) && (acc_cnt == ram_wait);
            acc_cnt   = acc_cnt + 1;
         end else begin
            mem_ready = 1'b0;
            acc_cnt   = 0;
         end
         mem_rdata = mem_ready ? ram_word : 32'h0BAD_0BAD;
      end
   end

   // Monitor: every reported outcome must match the head of the scoreboard.
   initial begin
      exp_t e;
      logic [2:0] want;
      forever begin
         @(negedge CLK);
         if (RESET === 1'b0 && (rdata_valid === 1'b1 || misalign === 1'b1 || bus_error === 1'b1)) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_outcome: rdata_valid=%b misalign=%b bus_error=%b rdata=%h, want no outcome",
                        rdata_valid, misalign, bus_error, rdata);
            end else begin
               e = sb_q.pop_front();
               want = (e.kind == K_DATA) ? 3'b100 : (e.kind == K_MIS) ? 3'b010 : 3'b001;
               if ({rdata_valid, misalign, bus_error} !== want ||
                   (e.kind != K_MIS && rdata !== e.rdata)) begin
                  fails++;
                  $display("FAIL outcome: got {rdata_valid,misalign,bus_error}=%b rdata=%h, want %b rdata=%h",
                           {rdata_valid, misalign, bus_error}, rdata, want, e.rdata);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input kind_t k, input logic [31:0] v);
      exp_t e;
      e.kind  = k;
      e.rdata = v;
      sb_q.push_back(e);
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   // One complete access: accept cycle, waits+1 ACCESS cycles, DONE cycle.
   task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                             input logic [31:0] word, input logic [9:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      ram_wait = waits;
      ram_word = word;
      if (!we) push(K_DATA, exp_rdata);
      drive_req(we, f3, addr, wdata);
      #1;
      tests++;
      if ({stall, mem_req} !== 2'b10) begin
         fails++;
         $display("FAIL %s accept: stall=%b mem_req=%b, want stall=1 mem_req=0", name, stall, mem_req);
      end
      step();
      req_valid = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         tests++;
         if ({stall, mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b1, we, exp_addr, exp_be} ||
             (we && mem_wdata !== exp_wdata)) begin
            fails++;
            $display("FAIL %s access%0d: stall=%b req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 %b %h %b %h",
                     name, i, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, we, exp_addr, exp_be, exp_wdata);
         end
         step();
      end
      tests++;
      if ({stall, mem_req} !== 2'b00) begin
         fails++;
         $display("FAIL %s done: stall=%b mem_req=%b, want 0 0", name, stall, mem_req);
      end
      step();
   endtask

   task automatic run_misalign(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr);
      push(K_MIS, 32'h0);
      drive_req(we, f3, addr, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if ({stall, mem_req} !== 2'b00) begin
            fails++;
            $display("FAIL %s cycle%0d: stall=%b mem_req=%b, want 0 0", name, i, stall, mem_req);
         end
         step();
         req_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      step();
      step();
      tests++;
      if ({stall, rdata, rdata_valid, misalign, bus_error, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
         fails++;
         $display("FAIL reset: stall=%b rdata=%h rv=%b mis=%b berr=%b req=%b we=%b addr=%h be=%b wdata=%h, want all 0",
                  stall, rdata, rdata_valid, misalign, bus_error, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
      end
      RESET = 1'b0;
      step();
   endtask

   task automatic test_loads();
      run_access("lw",  1'b0, 3'b010, 32'h0000_0008, 32'h0, 0, 32'hDEAD_BEEF, 10'd2, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      run_access("lb",  1'b0, 3'b000, 32'h0000_0003, 32'h0, 0, 32'h80FF_0102, 10'd0, 4'b1000, 32'h0, 32'hFFFF_FF80);
      run_access("lbu", 1'b0, 3'b100, 32'h0000_0003, 32'h0, 1, 32'h80FF_0102, 10'd0, 4'b1000, 32'h0, 32'h0000_0080);
      run_access("lh",  1'b0, 3'b001, 32'h0000_0012, 32'h0, 0, 32'h8001_7FFF, 10'd4, 4'b1100, 32'h0, 32'hFFFF_8001);
      run_access("lhu", 1'b0, 3'b101, 32'h0000_0010, 32'h0, 2, 32'h8001_FFFE, 10'd4, 4'b0011, 32'h0, 32'h0000_FFFE);
      // mem_ready on the last permitted ACCESS cycle still completes normally.
      run_access("lw_edge", 1'b0, 3'b010, 32'h0000_0FFC, 32'h0, 14, 32'h0123_4567, 10'h3FF, 4'b1111, 32'h0, 32'h0123_4567);
   endtask

   task automatic test_stores();
      run_access("sh", 1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 3, 32'h0, 10'd1, 4'b1100, 32'hABCD_ABCD, 32'h0);
      run_access("sb", 1'b1, 3'b000, 32'h0000_0021, 32'h0000_00A5, 0, 32'h0, 10'd8, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      run_access("sw", 1'b1, 3'b010, 32'h0000_002C, 32'hCAFE_F00D, 1, 32'h0, 10'd11, 4'b1111, 32'hCAFE_F00D, 32'h0);
   endtask

   task automatic test_misalign();
      run_misalign("mis_lw",   1'b0, 3'b010, 32'h0000_0002);
      run_misalign("mis_sw3",  1'b1, 3'b011, 32'h0000_0000);
      run_misalign("mis_lh",   1'b0, 3'b001, 32'h0000_0001);
      run_misalign("mis_sbu",  1'b1, 3'b100, 32'h0000_0000);
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      ram_wait = -1;
      push(K_BERR, 32'h0);
      drive_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
         req_cycles++;
         step();
      end
      tests++;
      if (req_cycles != 15 || mem_req !== 1'b0) begin
         fails++;
         $display("FAIL timeout_len: mem_req cycles=%0d (mem_req now %b), want 15 then 0", req_cycles, mem_req);
      end
      step();
   endtask

   task automatic test_back_to_back();
      ram_wait = 0;
      ram_word = 32'h1122_3344;
      push(K_DATA, 32'h1122_3344);
      push(K_DATA, 32'h0000_0033);
      drive_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
      step();
      req_valid = 1'b0;
      step();
      // DONE cycle of the first load: present the second request.
      drive_req(1'b0, 3'b100, 32'h0000_0011, 32'h0);
      #1;
      tests++;
      if (stall !== 1'b1) begin
         fails++;
         $display("FAIL b2b_accept: stall=%b, want 1", stall);
      end
      step();
      req_valid = 1'b0;
      tests++;
      if ({mem_req, mem_addr, mem_be} !== {1'b1, 10'd4, 4'b0010}) begin
         fails++;
         $display("FAIL b2b_access: req=%b addr=%h be=%b, want 1 004 0010", mem_req, mem_addr, mem_be);
      end
      step();
      step();
   endtask

   task automatic test_reset_in_access();
      ram_wait = 5;
      ram_word = 32'h5555_AAAA;
      drive_req(1'b0, 3'b010, 32'h0000_0020, 32'h0);
      step();
      req_valid = 1'b0;
      step();
      RESET = 1'b1;
      step();
      tests++;
      if ({mem_req, stall, rdata} !== {1'b0, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL reset_in_access: mem_req=%b stall=%b rdata=%h, want 0 0 00000000", mem_req, stall, rdata);
      end
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) step();
   endtask

   initial begin
      RESET = 1'b1;
      test_reset();
      test_loads();
      test_stores();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_in_access();
      step();
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d outcomes still expected, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Load/store unit between the pipelined core's MEM-stage data bus and a word-organised data RAM that answers with a ready handshake after a variable number of wait states.
- Takes byte, half-word and word access requests from the core, plus funct3.
- Generates word address, byte enables and lane-replicated write data.
- Sign- or zero-extends read data and stalls the pipeline until the RAM completes.
- Also flags misaligned accesses and RAM timeouts.

Parameters:
ADDR_W, 10, RAM word-address width; mem_addr = req_addr[ADDR_W+1:2].
TIMEOUT, 15, maximum ACCESS cycles waited for mem_ready before bus_error (1..255).

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  synchronous, active-high reset.
req_valid  in  1  core requests a memory access this cycle.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address (ALU result).
req_wdata  in  32  store data (rs2).
stall  out  1  hold the pipeline; combinational.
rdata  out  32  extended load data.
rdata_valid  out  1  1-cycle pulse: rdata valid.
misalign  out  1  1-cycle pulse: request rejected.
bus_error  out  1  1-cycle pulse: RAM timeout.
mem_req  out  1  RAM request, held until accepted.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_W  RAM word address.
mem_be  out  4  byte enables.
mem_wdata  out  32  lane-aligned write data.
mem_ready  in  1  RAM completes the access this cycle.
mem_rdata  in  32  RAM read word, valid when mem_ready=1.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (synchronous, wins over all else):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including rdata and latched request fields.
  - Reset during ACCESS abandons the transfer: mem_req=0 from the next cycle, no rdata_valid, no bus_error.
- Request acceptance, in IDLE or DONE when req_valid=1:
  - Legal when funct3 ∈ {000,100}; or funct3 ∈ {001,101} with addr[0]=0; or funct3=010 with addr[1:0]=00. Stores accept only 000/001/010.
  - Illegal request: misalign=1 next cycle; state→IDLE; no RAM access; stall stays 0.
  - Legal request: latch addr, we, funct3, be and lane data; state→ACCESS; stall=1 combinationally in the accept cycle.
- Byte enables:
  - B/BU: 0001<<addr[1:0].
  - H/HU: 0011<<(2*addr[1]).
  - W: 1111.
- Write data: byte replicated ×4; half replicated ×2; word as is.
- ACCESS:
  - mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata stable and stall=1.
  - Counter increments each ACCESS cycle.
  - mem_ready=1 → state→DONE. On a load, rdata is registered from mem_rdata:
    - B: sign-extend byte addr[1:0].
    - BU: zero-extend.
    - H: sign-extend half addr[1].
    - HU: zero-extend.
    - W: full word.
  - Counter reaches TIMEOUT with mem_ready=0 → mem_req drops, state→DONE, rdata=0, bus_error pulses in DONE.
  - mem_ready arriving on the same cycle as the TIMEOUT count counts as success.
- DONE (one cycle):
  - stall=0.
  - Load: rdata_valid=1.
  - Store: rdata_valid=0.
  - Counter cleared.
  - A new req_valid is accepted as in IDLE (back-to-back); otherwise →IDLE.
- rdata holds its value until the next load completes.
- mem_* outputs are 0 outside ACCESS.
- req_* inputs are ignored in ACCESS.
- Latency with a zero-wait RAM (mem_ready=1 in the first ACCESS cycle):
  - Accept at cycle 0, ACCESS at cycle 1, DONE at cycle 2.
  - stall high in cycles 0–1.
  - Each wait state adds one cycle.

Test Plan:
- After RESET: LW addr=0x0000_0008, mem_rdata=0xDEADBEEF, ready on first ACCESS cycle → mem_addr=2, mem_be=1111, stall 2 cycles, rdata=0xDEADBEEF with rdata_valid in cycle 2.
- LB and LBU at addr=0x0000_0003, mem_rdata=0x80FF_0102 → LB rdata=0xFFFF_FF80, LBU rdata=0x0000_0080, mem_be=1000.
- SH addr=0x0000_0006, req_wdata=0x1234_ABCD, ready after 3 wait states → mem_we=1, mem_addr=1, mem_be=1100, mem_wdata=0xABCD_ABCD held for 4 ACCESS cycles, stall 5 cycles, no rdata_valid.
- LW addr=0x0000_0002 and SW with funct3=011 → misalign pulse, mem_req never asserted, stall=0.
- mem_ready tied low, LW → mem_req high exactly TIMEOUT=15 cycles, bus_error pulse, rdata=0, no rdata_valid.
- Second request presented in the DONE cycle → accepted with no idle gap.
- RESET asserted in the 2nd ACCESS cycle → mem_req=0 next cycle, no rdata_valid or bus_error.
